// File: rtl/cart_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cart_mem_arbiter
// Purpose  : Serialises the mapper's PRG and CHR physical accesses onto one
//            request/acknowledge SDRAM port and returns read data to each path.
//            Each channel has a single-entry slot. Only one memory transaction
//            is outstanding at a time. CHR wins arbitration unless PRG has
//            waited through FAIR_MAX consecutive CHR grants.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Build option:
//   CART_MEM_CHR_WRITE_EN  defined  : CHR writes are issued to memory.
//                          undefined: CHR writes are discarded before capture.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   prg_req/we/addr/wdata/allow     PRG access strobe and qualifiers (in)
//   prg_rdata, prg_done             last PRG read data, completion pulse
//   chr_req/we/addr/wdata/allow     CHR access strobe and qualifiers (in)
//   chr_rdata, chr_done             last CHR read data, completion pulse
//   mem_req/we/addr/wdata           memory request, held until mem_ack
//   mem_ack, mem_rdata              memory completion and read data
//   overrun                         sticky dropped-request flags {chr, prg}
// ============================================================================
module cart_mem_arbiter #(
  parameter int FAIR_MAX = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prg_req,
  input  logic        prg_we,
  input  logic [21:0] prg_addr,
  input  logic [7:0]  prg_wdata,
  input  logic        prg_allow,
  output logic [7:0]  prg_rdata,
  output logic        prg_done,
  input  logic        chr_req,
  input  logic        chr_we,
  input  logic [21:0] chr_addr,
  input  logic [7:0]  chr_wdata,
  input  logic        chr_allow,
  output logic [7:0]  chr_rdata,
  output logic        chr_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [1:0]  overrun
);

  // Wide enough to hold FAIR_MAX itself (and at least one bit when it is 0).
  localparam int CW = $clog2(FAIR_MAX + 2);

`ifdef CART_MEM_CHR_WRITE_EN
  localparam logic C_CHR_WR_OK = 1'b1;
`else
  localparam logic C_CHR_WR_OK = 1'b0;
`endif

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t        state_q;
  logic          win_chr_q;     // channel owning the in-flight transaction
  logic [CW-1:0] fair_cnt_q;

  logic          prg_pend_q, prg_we_q;
  logic [21:0]   prg_addr_q;
  logic [7:0]    prg_wdata_q;
  logic          chr_pend_q, chr_we_q;
  logic [21:0]   chr_addr_q;
  logic [7:0]    chr_wdata_q;

  logic          mem_req_q, mem_we_q;
  logic [21:0]   mem_addr_q;
  logic [7:0]    mem_wdata_q;
  logic [7:0]    prg_rdata_q, chr_rdata_q;
  logic          prg_done_q, chr_done_q;
  logic [1:0]    overrun_q;

  logic w_ack, w_prg_take, w_chr_take, w_prg_free, w_chr_free;
  logic w_prg_cap, w_chr_cap, w_prg_eff, w_chr_eff;
  logic w_fair_force, w_grant_chr;

  assign w_ack      = (state_q == S_BUSY) & mem_ack;
  assign w_prg_take = prg_req & prg_allow;
  // Without CHR write support a CHR write never reaches the slot at all.
  assign w_chr_take = chr_req & chr_allow & (C_CHR_WR_OK | ~chr_we);

  // A slot is free if empty, or if its transaction is being acknowledged now.
  assign w_prg_free = ~prg_pend_q | (w_ack & ~win_chr_q);
  assign w_chr_free = ~chr_pend_q | (w_ack &  win_chr_q);
  assign w_prg_cap  = w_prg_take & w_prg_free;
  assign w_chr_cap  = w_chr_take & w_chr_free;

  // While idle, a request arriving this cycle is eligible immediately so
  // mem_req rises on the very next cycle; its fields bypass the slot.
  assign w_prg_eff    = prg_pend_q | w_prg_cap;
  assign w_chr_eff    = chr_pend_q | w_chr_cap;
  assign w_fair_force = w_prg_eff & (fair_cnt_q >= CW'(FAIR_MAX));
  assign w_grant_chr  = w_chr_eff & ~w_fair_force;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      win_chr_q   <= 1'b0;
      fair_cnt_q  <= '0;
      prg_pend_q  <= 1'b0;
      prg_we_q    <= 1'b0;
      prg_addr_q  <= '0;
      prg_wdata_q <= '0;
      chr_pend_q  <= 1'b0;
      chr_we_q    <= 1'b0;
      chr_addr_q  <= '0;
      chr_wdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      prg_rdata_q <= '0;
      chr_rdata_q <= '0;
      prg_done_q  <= 1'b0;
      chr_done_q  <= 1'b0;
      overrun_q   <= '0;
    end else begin
      prg_done_q <= 1'b0;
      chr_done_q <= 1'b0;

      // Completion: retire the winner's slot. Placed before capture so a
      // same-channel request in the ack cycle re-arms the slot.
      if (w_ack) begin
        if (win_chr_q) begin
          chr_pend_q <= 1'b0;
          chr_done_q <= 1'b1;
          if (!mem_we_q) chr_rdata_q <= mem_rdata;
        end else begin
          prg_pend_q <= 1'b0;
          prg_done_q <= 1'b1;
          if (!mem_we_q) prg_rdata_q <= mem_rdata;
        end
      end

      if (w_prg_take) begin
        if (w_prg_free) begin
          prg_pend_q  <= 1'b1;
          prg_we_q    <= prg_we;
          prg_addr_q  <= prg_addr;
          prg_wdata_q <= prg_wdata;
        end else begin
          overrun_q[0] <= 1'b1;
        end
      end

      if (w_chr_take) begin
        if (w_chr_free) begin
          chr_pend_q  <= 1'b1;
          chr_we_q    <= chr_we & C_CHR_WR_OK;
          chr_addr_q  <= chr_addr;
          chr_wdata_q <= chr_wdata;
        end else begin
          overrun_q[1] <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (w_prg_eff || w_chr_eff) begin
            state_q   <= S_BUSY;
            mem_req_q <= 1'b1;
            win_chr_q <= w_grant_chr;
            if (w_grant_chr) begin
              mem_we_q    <= (chr_pend_q ? chr_we_q    : chr_we) & C_CHR_WR_OK;
              mem_addr_q  <=  chr_pend_q ? chr_addr_q  : chr_addr;
              mem_wdata_q <=  chr_pend_q ? chr_wdata_q : chr_wdata;
              // Cannot overflow: a saturated count forces a PRG grant.
              if (w_prg_eff) fair_cnt_q <= fair_cnt_q + CW'(1);
            end else begin
              mem_we_q    <= prg_pend_q ? prg_we_q    : prg_we;
              mem_addr_q  <= prg_pend_q ? prg_addr_q  : prg_addr;
              mem_wdata_q <= prg_pend_q ? prg_wdata_q : prg_wdata;
              fair_cnt_q  <= '0;
            end
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign prg_rdata = prg_rdata_q;
  assign chr_rdata = chr_rdata_q;
  assign prg_done  = prg_done_q;
  assign chr_done  = chr_done_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire
